// File: rtl/vmc_pkg.sv
// Shared types and helpers for video_multi_compositor: layout modes, RGB565 colour-bar
// constants and the per-pixel region decode.
package vmc_pkg;

    typedef enum logic [1:0] {
        VMC_SINGLE = 2'd0,
        VMC_SPLIT  = 2'd1,
        VMC_QUAD   = 2'd2,
        VMC_PIP    = 2'd3
    } vmc_mode_e;

    localparam logic [15:0] VMC_WHITE   = 16'hFFFF;
    localparam logic [15:0] VMC_YELLOW  = 16'hFFE0;
    localparam logic [15:0] VMC_CYAN    = 16'h07FF;
    localparam logic [15:0] VMC_GREEN   = 16'h07E0;
    localparam logic [15:0] VMC_MAGENTA = 16'hF81F;
    localparam logic [15:0] VMC_RED     = 16'hF800;
    localparam logic [15:0] VMC_BLUE    = 16'h001F;
    localparam logic [15:0] VMC_BLACK   = 16'h0000;

    function automatic logic [15:0] vmc_bar(input logic [2:0] idx);
        case (idx)
            3'd0:    vmc_bar = VMC_WHITE;
            3'd1:    vmc_bar = VMC_YELLOW;
            3'd2:    vmc_bar = VMC_CYAN;
            3'd3:    vmc_bar = VMC_GREEN;
            3'd4:    vmc_bar = VMC_MAGENTA;
            3'd5:    vmc_bar = VMC_RED;
            3'd6:    vmc_bar = VMC_BLUE;
            default: vmc_bar = VMC_BLACK;
        endcase
    endfunction

    // Channel displayed at a pixel; right/bottom are half-screen flags, in_win is the PIP hit.
    function automatic logic [1:0] ch_of_xy(input vmc_mode_e mode, input logic [1:0] sel,
                                            input logic [1:0] win, input logic right,
                                            input logic bottom, input logic in_win);
        case (mode)
            VMC_SPLIT: ch_of_xy = {1'b0, right};
            VMC_QUAD:  ch_of_xy = {bottom, right};
            VMC_PIP:   ch_of_xy = in_win ? win : sel;
            default:   ch_of_xy = sel;
        endcase
    endfunction

endpackage

// File: rtl/vmc_delay_line.sv
// Fixed-depth shift register used to align display timing and channel selection with
// the pixels returned by the frame buffers.
module vmc_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         video_clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/video_multi_compositor.sv
// Multi-channel output compositor: display timing tracking, per-channel read requests,
// return alignment and SINGLE/SPLIT/QUAD/PIP muxing. VMC_TEST_PATTERN_EN enables colour bars.
module video_multi_compositor
    import vmc_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int H_ACT  = 1280,
    parameter int V_ACT  = 720,
    parameter int PIX_W  = 16,
    parameter int RD_LAT = 2,
    parameter int PIP_X0 = H_ACT / 2
) (
    input  logic                    video_clk,
    input  logic                    rst_n,
    input  logic                    video_vs,
    input  logic                    video_de,
    input  logic                    calib_done,
    input  logic [1:0]              mode,
    input  logic [1:0]              ch_sel,
    input  logic [CH_NUM-1:0]       ch_den,
    input  logic [CH_NUM*PIX_W-1:0] ch_data,
    output logic [CH_NUM-1:0]       ch_rd_de,
    output logic [CH_NUM-1:0]       ch_vs_n,
    output logic                    pix_de,
    output logic                    pix_vs,
    output logic [4:0]              pix_r,
    output logic [5:0]              pix_g,
    output logic [4:0]              pix_b,
    output logic [CH_NUM-1:0]       underflow
);

    localparam int XW = $clog2(H_ACT) + 2;
    localparam int YW = $clog2(V_ACT) + 2;
    localparam logic [2:0]    CH_LIM = 3'(CH_NUM);
    localparam logic [XW-1:0] X_HALF = XW'(H_ACT / 2);
    localparam logic [YW-1:0] Y_HALF = YW'(V_ACT / 2);
    localparam logic [XW-1:0] PIP_L  = XW'(PIP_X0);
    localparam logic [XW-1:0] PIP_R  = XW'(PIP_X0 + H_ACT / 2);

    logic            r_calib_meta, r_calib_sync;
    logic            r_de_q, r_vs_q, r_armed;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    vmc_mode_e       r_mode_q;
    logic [1:0]      r_sel_q;
    logic            w_vs_rise, w_de_fall;

    assign w_vs_rise = video_vs & ~r_vs_q;
    assign w_de_fall = ~video_de & r_de_q;

    // Stage p0: timing counters and frame-boundary latching of the layout controls
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_calib_meta <= 1'b0;
            r_calib_sync <= 1'b0;
            r_de_q       <= 1'b0;
            r_vs_q       <= 1'b0;
            r_armed      <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_mode_q     <= VMC_SINGLE;
            r_sel_q      <= 2'd0;
        end else begin
            r_calib_meta <= calib_done;
            r_calib_sync <= r_calib_meta;
            r_de_q       <= video_de;
            r_vs_q       <= video_vs;
            if (video_de)       r_x <= r_x + XW'(1);
            else if (w_de_fall) r_x <= '0;
            if (w_vs_rise)      r_y <= '0;
            else if (w_de_fall) r_y <= r_y + YW'(1);
            if (w_vs_rise) begin
                r_mode_q <= vmc_mode_e'(mode);
                r_sel_q  <= ({1'b0, ch_sel} >= CH_LIM) ? 2'd0 : ch_sel;
                r_armed  <= 1'b1;
            end
        end
    end

    logic [1:0]        w_win, w_disp_ch;
    logic              w_disp_ok, w_go, w_req_ok;
    logic [CH_NUM-1:0] w_req;

    assign w_win     = ({1'b0, r_sel_q} + 3'd1 >= CH_LIM) ? 2'd0 : r_sel_q + 2'd1;
    assign w_disp_ch = ch_of_xy(r_mode_q, r_sel_q, w_win, r_x >= X_HALF, r_y >= Y_HALF,
                                (r_x >= PIP_L) && (r_x < PIP_R) && (r_y < Y_HALF));
    assign w_disp_ok = {1'b0, w_disp_ch} < CH_LIM;
    assign w_go      = video_de & r_calib_sync & r_armed;
    assign w_req_ok  = w_go & w_disp_ok;

    // PIP keeps reading the background under the window so its line stride is unbroken
    always_comb begin
        w_req = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (w_disp_ok && w_disp_ch == 2'(k)) w_req[k] = 1'b1;
            if (r_mode_q == VMC_PIP && r_sel_q == 2'(k)) w_req[k] = 1'b1;
        end
    end

    logic [PIX_W-1:0] w_sub;
    logic             w_de_d, w_vs_d, w_req_d;
    logic [1:0]       w_sel_d;

`ifdef VMC_TEST_PATTERN_EN
    localparam int DL_W = 8;
    logic [2:0]      w_bar, w_bar_d;
    logic [DL_W-1:0] w_dl_in, w_dl_out;
    assign w_bar   = 3'(r_x / XW'(H_ACT / 8));
    assign w_dl_in = {w_bar, video_vs, video_de, w_req_ok, w_disp_ch};
    assign {w_bar_d, w_vs_d, w_de_d, w_req_d, w_sel_d} = w_dl_out;
    assign w_sub   = PIX_W'(vmc_bar(w_bar_d));
`else
    localparam int DL_W = 5;
    logic [DL_W-1:0] w_dl_in, w_dl_out;
    assign w_dl_in = {video_vs, video_de, w_req_ok, w_disp_ch};
    assign {w_vs_d, w_de_d, w_req_d, w_sel_d} = w_dl_out;
    assign w_sub   = '0;
`endif

    // Stage p1..p(1+RD_LAT): align timing with the frame-buffer return latency
    vmc_delay_line #(.W(DL_W), .DEPTH(1 + RD_LAT)) u_align (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .i_d       (w_dl_in),
        .o_q       (w_dl_out)
    );

    logic             w_den_sel;
    logic [PIX_W-1:0] w_data_sel;

    always_comb begin
        w_den_sel  = 1'b0;
        w_data_sel = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (w_sel_d == 2'(k)) begin
                w_den_sel  = ch_den[k];
                w_data_sel = ch_data[k*PIX_W +: PIX_W];
            end
        end
    end

    logic [CH_NUM-1:0] r_rd_de, r_vs_n, r_uf;
    logic              r_pix_de, r_pix_vs;
    logic [PIX_W-1:0]  r_pix;

    // Output stage: request registers and composited pixel
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_de  <= '0;
            r_vs_n   <= '1;
            r_uf     <= '0;
            r_pix_de <= 1'b0;
            r_pix_vs <= 1'b0;
            r_pix    <= '0;
        end else begin
            r_rd_de  <= w_go ? w_req : '0;
            r_vs_n   <= {CH_NUM{~video_vs}};
            r_pix_de <= w_de_d;
            r_pix_vs <= w_vs_d;
            if (!w_de_d)                 r_pix <= '0;
            else if (w_req_d && w_den_sel) r_pix <= w_data_sel;
            else                         r_pix <= w_sub;
            for (int k = 0; k < CH_NUM; k++) begin
                if (w_de_d && w_req_d && !w_den_sel && w_sel_d == 2'(k)) r_uf[k] <= 1'b1;
            end
        end
    end

    assign ch_rd_de  = r_rd_de;
    assign ch_vs_n   = r_vs_n;
    assign underflow = r_uf;
    assign pix_de    = r_pix_de;
    assign pix_vs    = r_pix_vs;
    assign pix_r     = r_pix[15:11];
    assign pix_g     = r_pix[10:5];
    assign pix_b     = r_pix[4:0];

endmodule

// File: tb/tb_video_multi_compositor.sv
// Self-checking bench for video_multi_compositor on a 64x16 raster with a frame-buffer model.
module tb_video_multi_compositor;

    localparam int CH_NUM = 4;
    localparam int H_ACT  = 64;
    localparam int V_ACT  = 16;
    localparam int PIX_W  = 16;
    localparam int RD_LAT = 2;
    localparam int LAG    = RD_LAT + 2;
`ifdef VMC_TEST_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic                    video_clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    video_vs = 1'b0;
    logic                    video_de = 1'b0;
    logic                    calib_done = 1'b0;
    logic [1:0]              mode = 2'd0;
    logic [1:0]              ch_sel = 2'd0;
    logic [CH_NUM-1:0]       ch_den;
    logic [CH_NUM*PIX_W-1:0] ch_data;
    logic [CH_NUM-1:0]       ch_rd_de, ch_vs_n, underflow;
    logic                    pix_de, pix_vs;
    logic [4:0]              pix_r, pix_b;
    logic [5:0]              pix_g;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 video_clk = ~video_clk;

    video_multi_compositor #(
        .CH_NUM(CH_NUM), .H_ACT(H_ACT), .V_ACT(V_ACT), .PIX_W(PIX_W), .RD_LAT(RD_LAT), .PIP_X0(H_ACT/2)
    ) dut (
        .video_clk(video_clk), .rst_n(rst_n), .video_vs(video_vs), .video_de(video_de),
        .calib_done(calib_done), .mode(mode), .ch_sel(ch_sel), .ch_den(ch_den), .ch_data(ch_data),
        .ch_rd_de(ch_rd_de), .ch_vs_n(ch_vs_n), .pix_de(pix_de), .pix_vs(pix_vs),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .underflow(underflow)
    );

    // Frame-buffer model: returns k*1111 two cycles after each request; can drop one ch0 pixel.
    logic [CH_NUM-1:0] m_p0 = '0, m_p1 = '0;
    logic m_vs_q = 1'b0;
    int   m_req0 = 0;
    bit   m_drop_en = 1'b0;
    int   m_drop_idx = 0;

    always @(posedge video_clk) begin
        m_vs_q <= video_vs;
        m_p1   <= m_p0;
        m_p0   <= ch_rd_de;
        if (video_vs && !m_vs_q) m_req0 <= 0;
        else if (ch_rd_de[0]) begin
            m_req0 <= m_req0 + 1;
            if (m_drop_en && m_req0 == m_drop_idx) m_p0[0] <= 1'b0;
        end
    end

    assign ch_den = m_p1;
    always_comb begin
        ch_data = '0;
        for (int k = 0; k < CH_NUM; k++)
            ch_data[k*PIX_W +: PIX_W] = m_p1[k] ? 16'(k * 16'h1111) : 16'hDEAD;
    end

    // Output monitor
    logic [LAG-1:0] h_de = '0, h_vs = '0;
    logic [15:0] cap [V_ACT][H_ACT];
    int de_bad, blk_bad, cap_n, cx, cy;
    int rd_cnt [CH_NUM];

    initial begin
        logic pv_q, pd_q;
        pv_q = 1'b0; pd_q = 1'b0; cx = 0; cy = 0;
        forever begin
            @(negedge video_clk);
            if (pix_de !== h_de[LAG-1] || pix_vs !== h_vs[LAG-1]) de_bad++;
            h_de = {h_de[LAG-2:0], video_de};
            h_vs = {h_vs[LAG-2:0], video_vs};
            if (pix_vs && !pv_q) begin cx = 0; cy = 0; end
            if (pix_de) begin
                if (cy < V_ACT && cx < H_ACT) cap[cy][cx] = {pix_r, pix_g, pix_b};
                cx++; cap_n++;
            end else begin
                if ({pix_r, pix_g, pix_b} !== 16'h0000) blk_bad++;
                if (pd_q) begin cx = 0; cy++; end
            end
            for (int k = 0; k < CH_NUM; k++) if (ch_rd_de[k] === 1'b1) rd_cnt[k]++;
            pv_q = pix_vs; pd_q = pix_de;
        end
    end

    // Reference model: displayed channel and pixel derived from the layout rules
    function automatic int disp_ch(int m, int s, int x, int y);
        case (m)
            0:       return s;
            1:       return (x < H_ACT/2) ? 0 : 1;
            2:       return ((y >= V_ACT/2) ? 2 : 0) + ((x >= H_ACT/2) ? 1 : 0);
            default: return (x >= H_ACT/2 && y < V_ACT/2) ? (s + 1) % CH_NUM : s;
        endcase
    endfunction

    function automatic logic [15:0] bar_of(int x);
        case (x / (H_ACT/8))
            0: return 16'hFFFF; 1: return 16'hFFE0; 2: return 16'h07FF; 3: return 16'h07E0;
            4: return 16'hF81F; 5: return 16'hF800; 6: return 16'h001F; default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] exp_sub(int x);
        return PAT ? bar_of(x) : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_pix(int m, int s, int x, int y, bit cal, bit drop);
        int c;
        c = disp_ch(m, s, x, y);
        if (!cal || c >= CH_NUM || drop) return exp_sub(x);
        return 16'(c * 16'h1111);
    endfunction

    task automatic run_frame(input int mid_mode);
        de_bad = 0; blk_bad = 0; cap_n = 0;
        for (int k = 0; k < CH_NUM; k++) rd_cnt[k] = 0;
        for (int y = 0; y < V_ACT; y++) for (int x = 0; x < H_ACT; x++) cap[y][x] = 16'hBEEF;
        @(posedge video_clk); #1 video_vs = 1'b1;
        repeat (4) @(posedge video_clk);
        #1 video_vs = 1'b0;
        repeat (6) @(posedge video_clk);
        for (int y = 0; y < V_ACT; y++) begin
            #1;
            if (y == 5 && mid_mode >= 0) mode = 2'(mid_mode);
            video_de = 1'b1;
            repeat (H_ACT) @(posedge video_clk);
            #1 video_de = 1'b0;
            repeat ($urandom_range(8, 20)) @(posedge video_clk);
        end
        repeat (10) @(posedge video_clk);
        #1;
    endtask

    task automatic check_frame(input string name, input int m, input int s, input bit cal,
                               input int dx, input int dy, input logic [3:0] exp_uf);
        int bad, fx, fy, exp_rd [CH_NUM];
        logic [15:0] fa, fe, e;
        bit [CH_NUM-1:0] set;
        bad = 0; fx = -1; fy = -1; fa = '0; fe = '0;
        for (int k = 0; k < CH_NUM; k++) exp_rd[k] = 0;
        for (int y = 0; y < V_ACT; y++) begin
            for (int x = 0; x < H_ACT; x++) begin
                e = exp_pix(m, s, x, y, cal, (x == dx && y == dy));
                if (cap[y][x] !== e) begin
                    bad++;
                    if (fx < 0) begin fx = x; fy = y; fa = cap[y][x]; fe = e; end
                end
                set = '0;
                if (cal) begin
                    if (disp_ch(m, s, x, y) < CH_NUM) set[disp_ch(m, s, x, y)] = 1'b1;
                    if (m == 3) set[s] = 1'b1;
                end
                for (int k = 0; k < CH_NUM; k++) exp_rd[k] += int'(set[k]);
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s pixels: %0d wrong, first (%0d,%0d) got %h expected %h", name, bad, fx, fy, fa, fe);
        end
        n_checks++;
        if (cap_n != H_ACT*V_ACT) begin
            n_fail++; $display("FAIL %s pix_count: got %0d expected %0d", name, cap_n, H_ACT*V_ACT);
        end
        n_checks++;
        if (de_bad != 0) begin
            n_fail++; $display("FAIL %s de_vs_lag: %0d cycles differ from video_de/vs delayed %0d, expected 0", name, de_bad, LAG);
        end
        n_checks++;
        if (blk_bad != 0) begin
            n_fail++; $display("FAIL %s blank_black: %0d non-zero pixels outside pix_de, expected 0", name, blk_bad);
        end
        for (int k = 0; k < CH_NUM; k++) begin
            n_checks++;
            if (rd_cnt[k] != exp_rd[k]) begin
                n_fail++; $display("FAIL %s rd_de_count ch%0d: got %0d expected %0d", name, k, rd_cnt[k], exp_rd[k]);
            end
        end
        n_checks++;
        if (underflow !== exp_uf) begin
            n_fail++; $display("FAIL %s underflow: got %b expected %b", name, underflow, exp_uf);
        end
    endtask

    task automatic spot(input string name, input int x, input int y, input logic [15:0] exp);
        n_checks++;
        if (cap[y][x] !== exp) begin
            n_fail++; $display("FAIL %s pixel(%0d,%0d): got %h expected %h", name, x, y, cap[y][x], exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge video_clk);
        #1;
        n_checks++;
        if ({ch_vs_n, ch_rd_de, underflow, pix_de, pix_vs, pix_r, pix_g, pix_b} !== {4'hF, 4'h0, 4'h0, 2'b00, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_state: vs_n=%b rd_de=%b uf=%b de=%b vs=%b pix=%h expected vs_n=1111 rest 0",
                     ch_vs_n, ch_rd_de, underflow, pix_de, pix_vs, {pix_r, pix_g, pix_b});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge video_clk);
    endtask

    task automatic test_no_calib();
        mode = 2'd0; ch_sel = 2'd0; calib_done = 1'b0;
        run_frame(-1); check_frame("no_calib_f1", 0, 0, 1'b0, -1, -1, 4'b0000);
        run_frame(-1); check_frame("no_calib_f2", 0, 0, 1'b0, -1, -1, 4'b0000);
        calib_done = 1'b1;
        repeat (5) @(posedge video_clk);
    endtask

    task automatic test_single();
        mode = 2'd0; ch_sel = 2'd2;
        run_frame(-1); check_frame("single_ch2", 0, 2, 1'b1, -1, -1, 4'b0000);
        spot("single_ch2", 63, 15, 16'h2222);
    endtask

    task automatic test_quad();
        mode = 2'd2; ch_sel = 2'd0;
        run_frame(-1); check_frame("quad", 2, 0, 1'b1, -1, -1, 4'b0000);
        spot("quad", 10, 3, 16'h0000);
        spot("quad", 40, 3, 16'h1111);
        spot("quad", 10, 12, 16'h2222);
        spot("quad", 40, 12, 16'h3333);
    endtask

    task automatic test_pip();
        mode = 2'd3; ch_sel = 2'd1;
        run_frame(-1); check_frame("pip_sel1", 3, 1, 1'b1, -1, -1, 4'b0000);
        spot("pip_sel1", 32, 0, 16'h2222);
        spot("pip_sel1", 31, 0, 16'h1111);
        spot("pip_sel1", 50, 8, 16'h1111);
    endtask

    task automatic test_mode_change();
        mode = 2'd0; ch_sel = 2'd0;
        run_frame(2); check_frame("midframe_single", 0, 0, 1'b1, -1, -1, 4'b0000);
        run_frame(-1); check_frame("next_frame_quad", 2, 0, 1'b1, -1, -1, 4'b0000);
    endtask

    task automatic test_random_frames();
        int m, s;
        for (int i = 0; i < 3; i++) begin
            m = $urandom_range(0, 3); s = $urandom_range(0, 3);
            mode = 2'(m); ch_sel = 2'(s);
            run_frame(-1);
            check_frame($sformatf("random%0d_m%0d_s%0d", i, m, s), m, s, 1'b1, -1, -1, 4'b0000);
        end
    endtask

    task automatic test_underflow();
        mode = 2'd0; ch_sel = 2'd0;
        m_drop_en = 1'b1; m_drop_idx = 5 * H_ACT + 5;
        run_frame(-1);
        m_drop_en = 1'b0;
        check_frame("underflow_drop", 0, 0, 1'b1, 5, 5, 4'b0001);
        spot("underflow_drop", 5, 5, exp_sub(5));
        spot("underflow_drop", 6, 5, 16'h0000);
        run_frame(-1); check_frame("underflow_sticky", 0, 0, 1'b1, -1, -1, 4'b0001);
    endtask

    task automatic test_async_reset();
        mode = 2'd2; ch_sel = 2'd0;
        @(posedge video_clk); #1 video_vs = 1'b1;
        repeat (4) @(posedge video_clk);
        #1 video_vs = 1'b0;
        repeat (6) @(posedge video_clk);
        #1 video_de = 1'b1;
        repeat (20) @(posedge video_clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ch_rd_de, pix_de, underflow, ch_vs_n, pix_r, pix_g, pix_b} !== {4'h0, 1'b0, 4'h0, 4'hF, 16'h0000}) begin
            n_fail++;
            $display("FAIL async_reset_drop: rd_de=%b de=%b uf=%b vs_n=%b pix=%h expected 0000 0 0000 1111 0000",
                     ch_rd_de, pix_de, underflow, ch_vs_n, {pix_r, pix_g, pix_b});
        end
        @(posedge video_clk); #1 rst_n = 1'b1;
        repeat (H_ACT - 22) @(posedge video_clk);
        #1 video_de = 1'b0;
        repeat (12) @(posedge video_clk);
        run_frame(-1); check_frame("after_async_reset", 2, 0, 1'b1, -1, -1, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_no_calib();
        test_single();
        test_quad();
        test_pip();
        test_mode_change();
        test_random_frames();
        test_underflow();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
